// File: rtl/mac_recv.sv
// Ethernet MAC receive path: destination filter, source/type capture, payload streaming
// through a 4-byte delay line so the trailing FCS is withheld, and end-of-frame FCS/length check.
module mac_recv #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int PROMISCUOUS   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_enable,
  input  logic [7:0]  data_in,
  input  logic [47:0] local_mac,
  output logic        active,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic [47:0] remote_mac,
  output logic [15:0] ethertype,
  output logic        is_broadcast,
  output logic [10:0] payload_len,
  output logic        frame_good,
  output logic        frame_bad
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DST, ST_SRC, ST_TYPE, ST_PAYLOAD, ST_CHECK, ST_DISCARD
  } state_t;

  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);
  localparam bit          PROMISC = (PROMISCUOUS != 0);

  state_t      state_q, state_d;
  logic [10:0] count_q, count_d;
  logic [31:0] dly_q, dly_d;
  logic [31:0] crc_q, crc_d;
  logic        local_match_q, local_match_d;
  logic        bcast_match_q, bcast_match_d;
  logic [47:0] src_shadow_q, src_shadow_d;
  logic [7:0]  type_hi_q, type_hi_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic [47:0] remote_mac_q, remote_mac_d;
  logic [15:0] ethertype_q, ethertype_d;
  logic        is_broadcast_q, is_broadcast_d;
  logic [10:0] payload_len_q, payload_len_d;
  logic        frame_good_q, frame_good_d;
  logic        frame_bad_q, frame_bad_d;

  logic [10:0] count_inc;
  logic [2:0]  mac_idx;
  logic        local_now, bcast_now;
  logic [31:0] crc_fcs;
  logic        fcs_ok, len_ok;

  // Reflected Ethernet CRC-32, one byte per call, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    case (idx)
      3'd0:    return mac[47:40];
      3'd1:    return mac[39:32];
      3'd2:    return mac[31:24];
      3'd3:    return mac[23:16];
      3'd4:    return mac[15:8];
      3'd5:    return mac[7:0];
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    dly_d          = rx_enable ? {dly_q[23:0], data_in} : dly_q;
    crc_d          = crc_q;
    local_match_d  = local_match_q;
    bcast_match_d  = bcast_match_q;
    src_shadow_d   = src_shadow_q;
    type_hi_d      = type_hi_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    remote_mac_d   = remote_mac_q;
    ethertype_d    = ethertype_q;
    is_broadcast_d = is_broadcast_q;
    payload_len_d  = payload_len_q;
    frame_good_d   = 1'b0;
    frame_bad_d    = 1'b0;

    count_inc = (count_q == 11'h7FF) ? count_q : count_q + 11'd1;
    mac_idx   = (state_q == ST_DST) ? count_q[2:0] : 3'd0;
    local_now = ((state_q == ST_DST) ? local_match_q : 1'b1) &&
                (data_in == mac_byte(local_mac, mac_idx));
    bcast_now = ((state_q == ST_DST) ? bcast_match_q : 1'b1) && (data_in == 8'hFF);

    crc_fcs = ~crc_q;
    fcs_ok  = (dly_q == {crc_fcs[7:0], crc_fcs[15:8], crc_fcs[23:16], crc_fcs[31:24]});
    len_ok  = (count_q >= MIN_LEN) && (count_q <= MAX_LEN);

    // Only bytes of the current frame (index >= 0) may leave the delay line into the CRC
    if (state_q == ST_IDLE || state_q == ST_CHECK) begin
      crc_d = '1;
    end else if (rx_enable && count_q >= 11'd4) begin
      crc_d = crc_byte(crc_q, dly_q[31:24]);
    end

    case (state_q)
      ST_IDLE, ST_CHECK: begin
        if (state_q == ST_CHECK) begin
          frame_good_d  = fcs_ok && len_ok;
          frame_bad_d   = !(fcs_ok && len_ok);
          payload_len_d = count_q - 11'd18;
        end
        if (rx_enable) begin
          state_d       = ST_DST;
          count_d       = 11'd1;
          local_match_d = local_now;
          bcast_match_d = bcast_now;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DST: begin
        if (!rx_enable) begin
          state_d = ST_IDLE;
        end else begin
          count_d       = count_inc;
          local_match_d = local_now;
          bcast_match_d = bcast_now;
          if (count_q == 11'd5) begin
            if (local_now || bcast_now || PROMISC) begin
              state_d        = ST_SRC;
              is_broadcast_d = bcast_now;
            end else begin
              state_d = ST_DISCARD;
            end
          end
        end
      end
      ST_SRC: begin
        if (!rx_enable) begin
          state_d = ST_IDLE;
        end else begin
          count_d      = count_inc;
          src_shadow_d = {src_shadow_q[39:0], data_in};
          if (count_q == 11'd11) state_d = ST_TYPE;
        end
      end
      ST_TYPE: begin
        if (!rx_enable) begin
          state_d = ST_IDLE;
        end else begin
          count_d = count_inc;
          if (count_q == 11'd12) begin
            type_hi_d = data_in;
          end else begin
            // Header complete: only now does the source/type become visible
            state_d      = ST_PAYLOAD;
            remote_mac_d = src_shadow_q;
            ethertype_d  = {type_hi_q, data_in};
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_enable) begin
          count_d = count_inc;
          if (count_q >= 11'd18) begin
            data_valid_d = 1'b1;
            data_out_d   = dly_q[31:24];
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_DISCARD: begin
        if (!rx_enable) state_d = ST_IDLE;
      end
      default: state_d = ST_DISCARD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_DISCARD;
      count_q        <= '0;
      dly_q          <= '0;
      crc_q          <= '1;
      local_match_q  <= 1'b0;
      bcast_match_q  <= 1'b0;
      src_shadow_q   <= '0;
      type_hi_q      <= '0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      remote_mac_q   <= '0;
      ethertype_q    <= '0;
      is_broadcast_q <= 1'b0;
      payload_len_q  <= '0;
      frame_good_q   <= 1'b0;
      frame_bad_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      dly_q          <= dly_d;
      crc_q          <= crc_d;
      local_match_q  <= local_match_d;
      bcast_match_q  <= bcast_match_d;
      src_shadow_q   <= src_shadow_d;
      type_hi_q      <= type_hi_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      remote_mac_q   <= remote_mac_d;
      ethertype_q    <= ethertype_d;
      is_broadcast_q <= is_broadcast_d;
      payload_len_q  <= payload_len_d;
      frame_good_q   <= frame_good_d;
      frame_bad_q    <= frame_bad_d;
    end
  end

  assign active       = !reset && (rx_enable || state_q != ST_IDLE);
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign remote_mac   = remote_mac_q;
  assign ethertype    = ethertype_q;
  assign is_broadcast = is_broadcast_q;
  assign payload_len  = payload_len_q;
  assign frame_good   = frame_good_q;
  assign frame_bad    = frame_bad_q;

endmodule

// File: tb/tb_mac_recv.sv
// Scoreboard bench for mac_recv: stimulus pushes expected payload bytes and end-of-frame
// records; a negedge monitor pops and compares whenever the DUT strobes.
module tb_mac_recv;

  localparam logic [47:0] LOCAL_MAC = 48'h001CC0A213DD;

  logic        clock, reset, rx_enable;
  logic [7:0]  data_in;
  logic [47:0] local_mac;
  logic        active, data_valid, is_broadcast, frame_good, frame_bad;
  logic [7:0]  data_out;
  logic [47:0] remote_mac;
  logic [15:0] ethertype;
  logic [10:0] payload_len;

  logic        p_active, p_data_valid, p_is_broadcast, p_frame_good, p_frame_bad;
  logic [7:0]  p_data_out;
  logic [47:0] p_remote_mac;
  logic [15:0] p_ethertype;
  logic [10:0] p_payload_len;

  mac_recv #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518), .PROMISCUOUS(0)) dut (
    .clock(clock), .reset(reset), .rx_enable(rx_enable), .data_in(data_in),
    .local_mac(local_mac), .active(active), .data_out(data_out), .data_valid(data_valid),
    .remote_mac(remote_mac), .ethertype(ethertype), .is_broadcast(is_broadcast),
    .payload_len(payload_len), .frame_good(frame_good), .frame_bad(frame_bad)
  );

  mac_recv #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518), .PROMISCUOUS(1)) dut_promisc (
    .clock(clock), .reset(reset), .rx_enable(rx_enable), .data_in(data_in),
    .local_mac(local_mac), .active(p_active), .data_out(p_data_out),
    .data_valid(p_data_valid), .remote_mac(p_remote_mac), .ethertype(p_ethertype),
    .is_broadcast(p_is_broadcast), .payload_len(p_payload_len),
    .frame_good(p_frame_good), .frame_bad(p_frame_bad)
  );

  typedef struct {
    bit          good;
    logic [10:0] len;
    logic [47:0] rmac;
    logic [15:0] etype;
    bit          bcast;
    int          cyc;
  } end_rec_t;

  logic [7:0] byte_q[$];
  end_rec_t   end_q[$];
  logic [7:0] frame_mem[0:2047];
  int         frame_len;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         promisc_goods = 0;
  int         promisc_before;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] bench_crc(input int n);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 8; b++) begin
        if (r[0] ^ frame_mem[k][b]) r = (r >> 1) ^ 32'hEDB88320;
        else                        r = r >> 1;
      end
    end
    return ~r;
  endfunction

  // Header + payload bytes 0,1,2,... + FCS; an optional payload byte is corrupted after the FCS
  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] et, input int plen, input int flip_idx);
    logic [31:0] fcs;
    for (int k = 0; k < 6; k++) begin
      frame_mem[k]     = dst[47-8*k -: 8];
      frame_mem[6 + k] = src[47-8*k -: 8];
    end
    frame_mem[12] = et[15:8];
    frame_mem[13] = et[7:0];
    for (int k = 0; k < plen; k++) frame_mem[14 + k] = k[7:0];
    frame_len = 14 + plen + 4;
    fcs = bench_crc(14 + plen);
    frame_mem[14 + plen]     = fcs[7:0];
    frame_mem[14 + plen + 1] = fcs[15:8];
    frame_mem[14 + plen + 2] = fcs[23:16];
    frame_mem[14 + plen + 3] = fcs[31:24];
    if (flip_idx >= 0) frame_mem[14 + flip_idx] = frame_mem[14 + flip_idx] ^ 8'hFF;
  endtask

  task automatic applyStimulus(input bit accept, input bit exp_good, input int cut,
                               input int reset_at, input int probe_idx, input int gap,
                               input logic [47:0] exp_rmac, input logic [15:0] exp_et,
                               input bit exp_bc);
    int n;
    end_rec_t e;
    n = (cut >= 0) ? cut : frame_len;
    if (accept) begin
      if (reset_at >= 0) begin
        for (int j = 14; j <= reset_at - 5; j++) byte_q.push_back(frame_mem[j]);
      end else if (cut < 0) begin
        for (int j = 14; j <= frame_len - 5; j++) byte_q.push_back(frame_mem[j]);
      end
    end
    for (int k = 0; k < n; k++) begin
      data_in   = frame_mem[k];
      rx_enable = 1'b1;
      reset     = (k == reset_at);
      @(posedge clock);
      #1;
      if (k == probe_idx) checkOutput("active mid-frame", 64'(active), 64'd1);
      if (k == reset_at) begin
        checkOutput("reset data_valid", 64'(data_valid), 64'd0);
        checkOutput("reset remote_mac", 64'(remote_mac), 64'd0);
        checkOutput("reset ethertype", 64'(ethertype), 64'd0);
        checkOutput("reset active", 64'(active), 64'd0);
      end
    end
    reset = 1'b0;
    if (accept && cut < 0 && reset_at < 0) begin
      e.good  = exp_good;
      e.len   = 11'(frame_len - 18);
      e.rmac  = exp_rmac;
      e.etype = exp_et;
      e.bcast = exp_bc;
      e.cyc   = cyc + 2;
      end_q.push_back(e);
    end
    rx_enable = 1'b0;
    data_in   = 8'h00;
    repeat (gap) @(posedge clock);
    #1;
  endtask

  // Monitor: compare every strobe against the scoreboard queues
  always @(negedge clock) begin
    end_rec_t e;
    if (p_frame_good === 1'b1) promisc_goods++;
    if (data_valid === 1'b1) begin
      if (byte_q.size() == 0) checkOutput("unexpected data_valid", 64'd1, 64'd0);
      else checkOutput("payload byte", 64'(data_out), 64'(byte_q.pop_front()));
    end
    if (frame_good === 1'b1 || frame_bad === 1'b1) begin
      if (end_q.size() == 0) begin
        checkOutput("unexpected end pulse", 64'd1, 64'd0);
      end else begin
        e = end_q.pop_front();
        checkOutput("frame_good", 64'(frame_good), 64'(e.good));
        checkOutput("frame_bad", 64'(frame_bad), 64'(!e.good));
        checkOutput("payload_len", 64'(payload_len), 64'(e.len));
        checkOutput("remote_mac", 64'(remote_mac), 64'(e.rmac));
        checkOutput("ethertype", 64'(ethertype), 64'(e.etype));
        checkOutput("is_broadcast", 64'(is_broadcast), 64'(e.bcast));
        checkOutput("end pulse cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    rx_enable = 1'b0;
    data_in   = 8'h00;
    local_mac = LOCAL_MAC;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset data_valid", 64'(data_valid), 64'd0);
    checkOutput("reset frame_good", 64'(frame_good), 64'd0);
    checkOutput("reset frame_bad", 64'(frame_bad), 64'd0);
    checkOutput("reset remote_mac", 64'(remote_mac), 64'd0);
    checkOutput("reset ethertype", 64'(ethertype), 64'd0);
    checkOutput("reset payload_len", 64'(payload_len), 64'd0);
    checkOutput("reset active", 64'(active), 64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("idle active", 64'(active), 64'd0);

    $display("[TB] good unicast frame");
    build_frame(LOCAL_MAC, 48'h112233445566, 16'h0800, 46, -1);
    applyStimulus(1, 1, -1, -1, -1, 4, 48'h112233445566, 16'h0800, 0);

    $display("[TB] broadcast frame");
    build_frame(48'hFFFFFFFFFFFF, 48'h112233445566, 16'h0806, 46, -1);
    applyStimulus(1, 1, -1, -1, -1, 4, 48'h112233445566, 16'h0806, 1);

    $display("[TB] foreign destination");
    promisc_before = promisc_goods;
    build_frame(48'h001CC0A213DE, 48'h112233445566, 16'h0800, 46, -1);
    applyStimulus(0, 0, -1, -1, 20, 4, 48'h0, 16'h0, 0);
    checkOutput("discard active after frame", 64'(active), 64'd0);
    checkOutput("promiscuous good count", 64'(promisc_goods - promisc_before), 64'd1);

    $display("[TB] corrupted payload byte");
    build_frame(LOCAL_MAC, 48'h112233445566, 16'h0800, 46, 10);
    applyStimulus(1, 0, -1, -1, -1, 4, 48'h112233445566, 16'h0800, 0);

    $display("[TB] oversize frame");
    build_frame(LOCAL_MAC, 48'h112233445566, 16'h0800, 1501, -1);
    applyStimulus(1, 0, -1, -1, -1, 4, 48'h112233445566, 16'h0800, 0);

    $display("[TB] undersize frame");
    build_frame(LOCAL_MAC, 48'h0A0B0C0D0E0F, 16'h0800, 42, -1);
    applyStimulus(1, 0, -1, -1, -1, 4, 48'h0A0B0C0D0E0F, 16'h0800, 0);

    $display("[TB] runt frame then good frame after one idle clock");
    build_frame(LOCAL_MAC, 48'hAABBCCDDEEFF, 16'h0806, 46, -1);
    applyStimulus(1, 0, 9, -1, -1, 1, 48'h0, 16'h0, 0);
    checkOutput("runt keeps remote_mac", 64'(remote_mac), 64'h0A0B0C0D0E0F);
    checkOutput("runt keeps ethertype", 64'(ethertype), 64'h0800);
    build_frame(LOCAL_MAC, 48'h112233445566, 16'h0800, 46, -1);
    applyStimulus(1, 1, -1, -1, -1, 4, 48'h112233445566, 16'h0800, 0);

    $display("[TB] reset mid-frame then good frame");
    build_frame(LOCAL_MAC, 48'h020304050607, 16'h0800, 46, -1);
    applyStimulus(1, 0, -1, 30, -1, 4, 48'h0, 16'h0, 0);
    build_frame(LOCAL_MAC, 48'h665544332211, 16'h86DD, 46, -1);
    applyStimulus(1, 1, -1, -1, -1, 4, 48'h665544332211, 16'h86DD, 0);

    repeat (4) @(posedge clock);
    #1;
    checkOutput("leftover payload bytes", 64'(byte_q.size()), 64'd0);
    checkOutput("leftover end records", 64'(end_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_recv.md
Name: mac_recv

Overview:
- Ethernet MAC receive path; the counterpart of the MAC transmit block.
- Accepts the frame byte stream from the PHY/RGMII receiver, with preamble and SFD already stripped.
- Filters on destination MAC (local or broadcast), latches source MAC and ethertype, and streams payload bytes to the IP/ARP layer.
- Checks the FCS with the shared crc32 block and pulses good/bad at end of frame. Downstream must drop buffered payload on frame_bad.

Parameters:
MIN_FRAME_LEN, 64, minimum accepted frame length in bytes, header through FCS inclusive
MAX_FRAME_LEN, 1518, maximum accepted frame length in bytes, FCS inclusive
PROMISCUOUS, 0, 1 = accept any destination MAC

Ports:
clock  in  1  byte clock
reset  in  1  synchronous, active-high
rx_enable  in  1  high while frame bytes are valid, one byte per clock, contiguous
data_in  in  8  frame byte, first destination-MAC byte first
local_mac  in  48  station MAC, [47:40] sent first on the wire
active  out  1  high while a frame is being received or discarded
data_out  out  8  payload byte
data_valid  out  1  data_out strobe
remote_mac  out  48  source MAC of the current/last accepted frame
ethertype  out  16  type/length field, first byte in [15:8]
is_broadcast  out  1  destination was FF:FF:FF:FF:FF:FF
payload_len  out  11  total bytes minus 18, valid with the end pulses
frame_good  out  1  one-cycle pulse: accepted frame, FCS and length OK
frame_bad  out  1  one-cycle pulse: accepted frame, FCS or length failed

Behaviour:
- Reset: state <= ST_DISCARD. All outputs 0, byte counter 0, delay line cleared. Reset mid-frame abandons the frame with no end pulse.
- States:
  - ST_IDLE: rx_enable high -> ST_DST. The byte sampled at that edge is byte 0.
  - ST_DST (bytes 0-5): compare each byte against local_mac[47-8i -: 8] and against 8'hFF; keep two running match flags. After byte 5: a match (or PROMISCUOUS) -> ST_SRC, latch is_broadcast; no match -> ST_DISCARD.
  - ST_SRC (bytes 6-11): shift into remote_mac. Update remote_mac only if the frame reaches ST_PAYLOAD; use a shadow register.
  - ST_TYPE (bytes 12-13): load ethertype -> ST_PAYLOAD.
  - ST_PAYLOAD: stay while rx_enable is high. On rx_enable low -> ST_CHECK.
  - ST_CHECK: one cycle. Drive frame_good or frame_bad plus payload_len -> ST_IDLE.
  - ST_DISCARD: wait for rx_enable low -> ST_IDLE. No outputs.
- rx_enable low in ST_DST, ST_SRC or ST_TYPE: runt. Go to ST_IDLE with no pulse; remote_mac and ethertype keep their previous values.
- Delay line:
  - 4-byte shift register, advanced only on edges where rx_enable is high. Its output byte feeds crc32 (clear = state==ST_IDLE, enable = shift).
  - The byte leaving the delay line is presented on data_out with data_valid=1 in the cycle after it leaves, if its index >= 14. A payload byte sampled at edge n therefore appears after the 4th following sampled byte.
  - The 4 bytes left in the delay line at end of frame are the FCS and never appear on data_out.
- FCS check in ST_CHECK: delay line, oldest to newest, must equal {crc[7:0], crc[15:8], crc[23:16], crc[31:24]}. crc is computed over all earlier bytes.
- Length: 11-bit byte counter, saturating at 2047. frame_good requires MIN_FRAME_LEN <= count <= MAX_FRAME_LEN and FCS match; otherwise frame_bad.
- payload_len = count - 18, and includes padding. Upper layers trim it using the IP length field.
- Frames must be separated by at least 1 idle clock. Back-to-back rx_enable with no gap is merged into one frame and fails FCS.
- active = !reset && (rx_enable || state != ST_IDLE).
- Latency: rx_enable fall to end pulse = 2 clocks.
- Exactly one of frame_good/frame_bad per accepted frame. Neither pulse for discarded frames or runts.

Test Plan:
- 64-byte frame, dst = local_mac 00:1C:C0:A2:13:DD, src 11:22:33:44:55:66, type 0800, 46 payload bytes 00..2D, correct FCS -> 46 data_valid strobes with bytes 00..2D in order, remote_mac=112233445566, ethertype=16'h0800, is_broadcast=0, frame_good after 2 clocks, payload_len=46.
- Same frame with dst FF:FF:FF:FF:FF:FF, type 0806 -> accepted, is_broadcast=1, frame_good.
- Dst 00:1C:C0:A2:13:DE -> no data_valid, no pulses, active high until rx_enable falls; PROMISCUOUS=1 rerun -> frame_good.
- First frame with payload byte 10 flipped -> frame_bad, payload bytes still streamed; 1519-byte good-FCS frame -> frame_bad; 60-byte frame with correct FCS -> frame_bad.
- rx_enable dropped after 9 bytes -> no pulses, remote_mac keeps the previous frame's value; next good frame after 1 idle clock -> frame_good.
- Reset asserted at byte 30 with rx_enable still high -> outputs 0, remaining bytes ignored; next frame -> frame_good.
